// File: rtl/aidan_mccoy.sv
// aidan_mccoy: 6-bit accumulator cpu, one instruction per clock.
// io_in = {instr[5:0], rst_n, clk}; io_out = {neg, zero, acc[5:0]}.
module aidan_mccoy (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_LI  = 3'b001,
    OP_SUB = 3'b010,
    OP_ADD = 3'b011,
    OP_LR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SR  = 3'b110,
    OP_NOT = 3'b111
  } op_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] f;
  op_t        op;

  assign clk   = io_in[0];
  assign rst_n = io_in[1];
  assign f     = io_in[7:5];
  assign op    = op_t'(io_in[4:2]);

  logic [5:0] acc;
  logic [5:0] acc_nx;
  logic [5:0] regs [8];
  logic [5:0] rv;

  assign rv = regs[f];

  always_comb begin
    acc_nx = acc;
    unique case (op)
      OP_NOP: acc_nx = acc;
      OP_LI:  acc_nx = {{3{f[2]}}, f};
      OP_SUB: acc_nx = acc - rv;
      OP_ADD: acc_nx = acc + rv;
      OP_LR:  acc_nx = rv;
      OP_XOR: acc_nx = acc ^ rv;
      OP_SR:  acc_nx = acc;
      OP_NOT: acc_nx = ~acc;
      default: acc_nx = acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      for (int i = 0; i < 8; i++)
        regs[i] <= '0;
    end else begin
      acc <= acc_nx;
      if (op == OP_SR)
        regs[f] <= acc;
    end
  end

  assign io_out = {acc[5], ~|acc, acc};

endmodule

// File: tb/tb_aidan_mccoy.sv
// tb_aidan_mccoy: scoreboard bench for aidan_mccoy.
// Directed program fragments plus random instructions and resets.
module tb_aidan_mccoy;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] instr = 6'd0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {instr, rst_n, clk};

  aidan_mccoy dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] NOP = 3'd0;
  localparam logic [2:0] LI  = 3'd1;
  localparam logic [2:0] SUB = 3'd2;
  localparam logic [2:0] ADD = 3'd3;
  localparam logic [2:0] LR  = 3'd4;
  localparam logic [2:0] XOR = 3'd5;
  localparam logic [2:0] SR  = 3'd6;
  localparam logic [2:0] NOT = 3'd7;

  int errors = 0;
  int checks = 0;

  // reference state held as plain integers in 0..63
  int m_acc;
  int m_regs [8];

  typedef struct {
    logic [7:0] val;
    string      tag;
  } exp_t;
  exp_t sb [$];

  function automatic logic [7:0] pins(input int a);
    int v;
    v = a;
    if (a >= 32) v = v + 128;
    if (a == 0) v = v + 64;
    return 8'(v);
  endfunction

  task automatic model_reset();
    m_acc = 0;
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
  endtask

  task automatic exec(input logic [2:0] op, input int fld,
                      input string tag);
    exp_t e;
    @(negedge clk);
    instr = {3'(fld), op};
    case (op)
      LI:  m_acc = (fld >= 4) ? fld - 8 + 64 : fld;
      SUB: m_acc = (m_acc - m_regs[fld] + 64) % 64;
      ADD: m_acc = (m_acc + m_regs[fld]) % 64;
      LR:  m_acc = m_regs[fld];
      XOR: m_acc = m_acc ^ m_regs[fld];
      SR:  m_regs[fld] = m_acc;
      NOT: m_acc = 63 - m_acc;
      default: ;
    endcase
    e.val = pins(m_acc);
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic expect_acc(input int a, input string tag);
    checks++;
    if (m_acc != a) begin
      errors++;
      $display("FAIL model %s: got %0d want %0d", tag, m_acc, a);
    end
  endtask

  task automatic async_reset(input int hold, input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (io_out !== 8'h40) begin
      errors++;
      $display("FAIL %s: io_out=%h want 40", tag, io_out);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      instr = 6'($urandom);
    end
    @(negedge clk);
    checks++;
    if (io_out !== 8'h40) begin
      errors++;
      $display("FAIL %s hold: io_out=%h want 40", tag, io_out);
    end
    rst_n = 1'b1;
    instr = {3'd0, NOP};
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (io_out !== e.val) begin
        errors++;
        $display("FAIL %s: io_out=%b want %b", e.tag, io_out, e.val);
      end
    end
  end

  initial begin
    model_reset();
    #7;
    checks++;
    if (io_out !== 8'h40) begin
      errors++;
      $display("FAIL reset: io_out=%h want 40", io_out);
    end
    @(negedge clk);
    rst_n = 1'b1;

    exec(LI, 3, "li3");
    exec(SR, 2, "sr2");
    exec(LI, 4, "li-4");
    exec(SR, 3, "sr3");
    exec(LI, 2, "li2");
    exec(ADD, 2, "add_5");
    expect_acc(5, "add_5");
    exec(LI, 2, "li2b");
    exec(ADD, 3, "add_-2");
    expect_acc(62, "add_-2");

    exec(LI, 3, "li3r");
    exec(SR, 1, "sr1");
    exec(ADD, 1, "rep6");
    exec(ADD, 1, "rep9");
    exec(ADD, 1, "rep12");
    expect_acc(12, "rep12");

    exec(NOT, 5, "not12");
    expect_acc(51, "not12");
    exec(SR, 1, "sr1n");
    exec(LI, 1, "li1");
    exec(ADD, 1, "add_-12");
    exec(SR, 1, "sr1m");
    exec(LI, 3, "li3n");
    exec(ADD, 1, "add_-9");
    expect_acc(55, "add_-9");

    exec(LI, 1, "li1w");
    for (int i = 0; i < 5; i++) begin
      exec(SR, 4, "dbl_sr");
      exec(ADD, 4, "dbl_add");
    end
    exec(NOT, 0, "not_31");
    expect_acc(31, "build31");
    exec(SR, 4, "sr4");
    exec(LI, 1, "li1x");
    exec(ADD, 4, "wrap");
    expect_acc(32, "wrap");
    exec(LI, 0, "li0");
    exec(SUB, 4, "sub_-31");
    expect_acc(33, "sub_-31");

    exec(LI, 3, "li3z");
    exec(SR, 5, "sr5");
    exec(XOR, 5, "xor_zero");
    exec(LR, 5, "lr5");
    exec(NOP, 6, "nop");

    exec(LI, 3, "li3q");
    exec(SR, 2, "sr2q");
    exec(ADD, 2, "six");
    exec(ADD, 2, "nine");
    expect_acc(9, "nine");
    async_reset(2, "midreset");
    exec(LR, 2, "lr2_post");
    exec(LR, 7, "lr7_post");

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0)
        async_reset($urandom_range(0, 2), "rnd_reset");
      else
        exec(3'($urandom), $urandom_range(0, 7), "rnd");
    end

    for (int t = 0; t < 10 && sb.size() > 0; t++)
      @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: left=%0d want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
